// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_pkg : shared types and constants for the AES load sequencer      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package aes_pkg;

  localparam int AES_W = 128;

  localparam logic [1:0] SEL_KEY  = 2'd0;
  localparam logic [1:0] SEL_IV   = 2'd1;
  localparam logic [1:0] SEL_CT   = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LD_KEY = 3'd1,
    ST_LD_IV  = 3'd2,
    ST_LD_BLK = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } aes_ld_state_t;

endpackage
`default_nettype wire

// File: rtl/aes_share_refresh.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_share_refresh : remasks a Boolean-shared word with fresh masks   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module aes_share_refresh
  import aes_pkg::*;
#(
  parameter int SHARES = 3
) (
  input  logic [AES_W-1:0] d_i    [SHARES],
  input  logic [AES_W-1:0] rand_i [SHARES-1],
  output logic [AES_W-1:0] d_o    [SHARES]
);

  logic [AES_W-1:0] w_rand_acc;

  // Each mask is applied twice overall, so the XOR across all shares is preserved.
  always_comb begin
    w_rand_acc = '0;
    for (int j = 0; j < SHARES - 1; j++) begin
      d_o[j]     = d_i[j] ^ rand_i[j];
      w_rand_acc = w_rand_acc ^ rand_i[j];
    end
    d_o[SHARES-1] = d_i[SHARES-1] ^ w_rand_acc;
  end

endmodule
`default_nettype wire

// File: rtl/aes_load_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_load_seq : loads key, IV and N ciphertext blocks from the masked |
// | input mux, remasking each capture. Rev 1.0                           |
// +----------------------------------------------------------------------+
module aes_load_seq
  import aes_pkg::*;
#(
  parameter int SHARES = 3,
  parameter int CNT_W  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [CNT_W-1:0]    nblocks_i,
  output logic [1:0]          sel_o,
  input  logic [AES_W-1:0]    d_i    [SHARES],
  input  logic                valid_i,
  input  logic [AES_W-1:0]    rand_i [SHARES-1],
  output logic [AES_W-1:0]    key_o  [SHARES],
  output logic [AES_W-1:0]    iv_o   [SHARES],
  output logic [AES_W-1:0]    blk_o  [SHARES],
  output logic                blk_valid_o,
  input  logic                blk_ready_i,
  output logic                busy_o,
  output logic                done_o
);

  aes_ld_state_t    state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [AES_W-1:0] key_q [SHARES];
  logic [AES_W-1:0] iv_q  [SHARES];
  logic [AES_W-1:0] blk_q [SHARES];
  logic             w_cap_key, w_cap_iv, w_cap_blk;
  logic [AES_W-1:0] w_refreshed [SHARES];

  // One refresh instance serves all capture registers; only one loads per cycle.
  aes_share_refresh #(
    .SHARES (SHARES)
  ) u_refresh (
    .d_i    (d_i),
    .rand_i (rand_i),
    .d_o    (w_refreshed)
  );

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    w_cap_key = 1'b0;
    w_cap_iv  = 1'b0;
    w_cap_blk = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_LD_KEY;
          rem_d   = nblocks_i;
        end
      end
      ST_LD_KEY: begin
        if (valid_i) begin
          w_cap_key = 1'b1;
          state_d   = ST_LD_IV;
        end
      end
      ST_LD_IV: begin
        if (valid_i) begin
          w_cap_iv = 1'b1;
          state_d  = (rem_q == '0) ? ST_DONE : ST_LD_BLK;
        end
      end
      ST_LD_BLK: begin
        if (valid_i) begin
          w_cap_blk = 1'b1;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (blk_ready_i) begin
          if (rem_q != '0) begin
            rem_d = rem_q - CNT_W'(1);
          end
          state_d = (rem_q <= CNT_W'(1)) ? ST_DONE : ST_LD_BLK;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      key_q   <= '{default: '0};
      iv_q    <= '{default: '0};
      blk_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (w_cap_key) key_q <= w_refreshed;
      if (w_cap_iv)  iv_q  <= w_refreshed;
      if (w_cap_blk) blk_q <= w_refreshed;
    end
  end

  always_comb begin
    case (state_q)
      ST_LD_KEY: sel_o = SEL_KEY;
      ST_LD_IV:  sel_o = SEL_IV;
      ST_LD_BLK: sel_o = SEL_CT;
      default:   sel_o = SEL_NONE;
    endcase
  end

  // Handshake valid is pure state decode, never a function of blk_ready_i.
  assign blk_valid_o = (state_q == ST_HOLD);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign key_o       = key_q;
  assign iv_o        = iv_q;
  assign blk_o       = blk_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_load_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_aes_load_seq : directed self-checking bench for aes_load_seq      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_aes_load_seq;

  localparam logic [127:0] C_K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_R0 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] C_R1 = 128'ha5a5_5a5a_0f0f_f0f0_1234_5678_9abc_def0;
  localparam logic [127:0] C_R2 = 128'hdead_beef_cafe_f00d_0123_4567_89ab_cdef;
  localparam logic [127:0] C_R3 = 128'h0bad_c0de_face_b00c_fedc_ba98_7654_3210;
  localparam logic [127:0] C_IA = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C_IB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_IC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_B0 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C_B1 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  int checks = 0;
  int errors = 0;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [15:0]  nblocks;
  logic [1:0]   sel;
  logic [127:0] d    [3];
  logic         valid;
  logic [127:0] rnd  [2];
  logic [127:0] key  [3];
  logic [127:0] iv   [3];
  logic [127:0] blk  [3];
  logic         blk_valid, blk_ready, busy, done;

  logic         start4;
  logic [3:0]   nb4;
  logic [1:0]   sel4;
  logic [127:0] d4   [2];
  logic         valid4;
  logic [127:0] rnd4 [1];
  logic [127:0] key4 [2];
  logic [127:0] iv4  [2];
  logic [127:0] blk4 [2];
  logic         blk_valid4, ready4, busy4, done4;

  always #5 clk = ~clk;

  aes_load_seq #(.SHARES(3), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .nblocks_i(nblocks), .sel_o(sel),
    .d_i(d), .valid_i(valid), .rand_i(rnd), .key_o(key), .iv_o(iv), .blk_o(blk),
    .blk_valid_o(blk_valid), .blk_ready_i(blk_ready), .busy_o(busy), .done_o(done)
  );

  aes_load_seq #(.SHARES(2), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .nblocks_i(nb4), .sel_o(sel4),
    .d_i(d4), .valid_i(valid4), .rand_i(rnd4), .key_o(key4), .iv_o(iv4), .blk_o(blk4),
    .blk_valid_o(blk_valid4), .blk_ready_i(ready4), .busy_o(busy4), .done_o(done4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({sel, busy, done, blk_valid} !== 5'b11_000) begin
      errors++;
      $display("FAIL reset_ctrl: got sel/busy/done/vld=%b expected 11000", {sel, busy, done, blk_valid});
    end
    checks++;
    if ({key[0], key[1], key[2], iv[0], iv[1], iv[2], blk[0], blk[1], blk[2]} !== '0) begin
      errors++;
      $display("FAIL reset_data: got key0=%h iv0=%h blk0=%h expected zero", key[0], iv[0], blk[0]);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_run();
    logic [127:0] k_exp [3];
    nblocks = 16'd2; valid = 1'b1; blk_ready = 1'b1;
    d = '{C_K, '0, '0}; rnd = '{C_R0, C_R1};
    start = 1'b1;
    step();                                   // cycle 1: LD_KEY
    start = 1'b0;
    checks++;
    if (sel !== 2'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL run_ld_key: got sel=%0d busy=%b expected sel=0 busy=1", sel, busy);
    end
    step();                                   // cycle 2: LD_IV
    k_exp = '{C_K ^ C_R0, C_R1, C_R0 ^ C_R1};
    checks++;
    if ({key[0], key[1], key[2]} !== {k_exp[0], k_exp[1], k_exp[2]}) begin
      errors++;
      $display("FAIL run_key_shares: got %h %h %h expected %h %h %h", key[0], key[1], key[2], k_exp[0], k_exp[1], k_exp[2]);
    end
    checks++;
    if (sel !== 2'd1) begin errors++; $display("FAIL run_sel_iv: got %0d expected 1", sel); end
    d = '{C_IA, C_IB, C_IC}; rnd = '{C_R2, C_R3};
    step();                                   // cycle 3: LD_BLK
    checks++;
    if ((iv[0] ^ iv[1] ^ iv[2]) !== (C_IA ^ C_IB ^ C_IC) || iv[2] !== (C_IC ^ C_R2 ^ C_R3)) begin
      errors++;
      $display("FAIL run_iv: got xor=%h s2=%h expected xor=%h s2=%h", iv[0] ^ iv[1] ^ iv[2], iv[2], C_IA ^ C_IB ^ C_IC, C_IC ^ C_R2 ^ C_R3);
    end
    d = '{C_B0, '0, '0};
    step();                                   // cycle 4: HOLD
    checks++;
    if (blk_valid !== 1'b1 || sel !== 2'd3 || (blk[0] ^ blk[1] ^ blk[2]) !== C_B0) begin
      errors++;
      $display("FAIL run_blk0: got vld=%b sel=%0d xor=%h expected 1 3 %h", blk_valid, sel, blk[0] ^ blk[1] ^ blk[2], C_B0);
    end
    d = '{C_B1, '0, '0};
    step();                                   // cycle 5: LD_BLK
    checks++;
    if (blk_valid !== 1'b0 || sel !== 2'd2) begin
      errors++; $display("FAIL run_refetch: got vld=%b sel=%0d expected 0 2", blk_valid, sel);
    end
    step();                                   // cycle 6: HOLD
    checks++;
    if ((blk[0] ^ blk[1] ^ blk[2]) !== C_B1 || done !== 1'b0) begin
      errors++; $display("FAIL run_blk1: got xor=%h done=%b expected %h 0", blk[0] ^ blk[1] ^ blk[2], done, C_B1);
    end
    step();                                   // cycle 7: DONE
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL run_done_at_7: got %b expected 1", done); end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || key[0] !== k_exp[0]) begin
      errors++; $display("FAIL run_idle_after: got done=%b busy=%b key0=%h expected 0 0 %h", done, busy, key[0], k_exp[0]);
    end
  endtask

  task automatic test_zero_blocks();
    logic [1:0] seq [3];
    logic       seen_vld = 1'b0;
    logic       done_ok  = 1'b0;
    nblocks = 16'd0; valid = 1'b1; blk_ready = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      start = 1'b0;
      seq[i] = sel;
      if (blk_valid) seen_vld = 1'b1;
      if (i == 2) done_ok = done;
    end
    checks++;
    if ({seq[0], seq[1], seq[2]} !== 6'b00_01_11) begin
      errors++; $display("FAIL zero_sel_seq: got %0d,%0d,%0d expected 0,1,3", seq[0], seq[1], seq[2]);
    end
    checks++;
    if (seen_vld !== 1'b0 || done_ok !== 1'b1) begin
      errors++; $display("FAIL zero_done: got blk_valid_seen=%b done=%b expected 0 1", seen_vld, done_ok);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [383:0] held;
    nblocks = 16'd1; valid = 1'b1; blk_ready = 1'b0;
    d = '{C_B0, C_B1, '0};
    start = 1'b1;
    step(); start = 1'b0;
    step();
    step();
    checks++;
    if (sel !== 2'd2) begin errors++; $display("FAIL bp_ld_blk: got sel=%0d expected 2", sel); end
    step();
    held = {blk[0], blk[1], blk[2]};
    for (int i = 0; i < 5; i++) begin
      d = '{~C_B0, C_R1, C_R2};
      valid = i[0];
      step();
      checks++;
      if ({blk[0], blk[1], blk[2]} !== held || sel !== 2'd3 || blk_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d: got blk0=%h sel=%0d vld=%b expected blk0=%h 3 1", i, blk[0], sel, blk_valid, held[383:256]);
      end
    end
    blk_ready = 1'b1;
    step();
    checks++;
    if (blk_valid !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL bp_accept: got vld=%b done=%b expected 0 1", blk_valid, done);
    end
    valid = 1'b1;
    step();
  endtask

  task automatic test_stall();
    int hs = 0;
    int dones = 0;
    nblocks = 16'd2; valid = 1'b1; blk_ready = 1'b1;
    start = 1'b1;
    step(); start = 1'b0;
    step();                                   // LD_IV
    valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      nblocks = 16'd7;
      step();
      checks++;
      if (sel !== 2'd1 || busy !== 1'b1) begin
        errors++; $display("FAIL stall_%0d: got sel=%0d busy=%b expected 1 1", i, sel, busy);
      end
    end
    start = 1'b0;
    valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (blk_valid && blk_ready) hs++;
      step();
      if (done) dones++;
    end
    checks++;
    if (hs != 2 || dones != 1) begin
      errors++; $display("FAIL stall_blocks: got handshakes=%0d dones=%0d expected 2 1", hs, dones);
    end
  endtask

  task automatic test_reset_mid();
    nblocks = 16'd3; valid = 1'b1; blk_ready = 1'b1;
    start = 1'b1;
    step(); start = 1'b0;
    step();
    step();                                   // LD_BLK, source stalled
    valid = 1'b0;
    checks++;
    if (sel !== 2'd2 || key[0] === '0) begin
      errors++; $display("FAIL mid_pre: got sel=%0d key0=%h expected sel=2 key0 nonzero", sel, key[0]);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({sel, busy, done, blk_valid} !== 5'b11_000 ||
        {key[0], key[1], key[2], iv[0], iv[1], iv[2], blk[0], blk[1], blk[2]} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got sel=%0d busy=%b vld=%b key0=%h blk0=%h expected 3 0 0 0 0", sel, busy, blk_valid, key[0], blk[0]);
    end
    valid = 1'b1;
    step();
  endtask

  task automatic test_counter_width();
    int hs = 0;
    int dones = 0;
    int c = 0;
    // Wide counter: run well past the low byte and confirm no early completion.
    nblocks = 16'hFFFF; blk_ready = 1'b0;
    start = 1'b1;
    step(); start = 1'b0;
    while (hs < 600 && c < 5000) begin
      valid     = ($urandom_range(0, 3) != 0);
      blk_ready = ($urandom_range(0, 2) != 0);
      d   = '{$urandom, $urandom, $urandom};
      rnd = '{$urandom, $urandom};
      if (blk_valid && blk_ready) hs++;
      step();
      if (done) dones++;
      c++;
    end
    checks++;
    if (hs != 600 || dones != 0 || busy !== 1'b1) begin
      errors++; $display("FAIL cnt16_partial: got hs=%0d dones=%0d busy=%b expected 600 0 1", hs, dones, busy);
    end
    rst = 1'b1; step(); rst = 1'b0;
    blk_ready = 1'b1; valid = 1'b1;

    // Narrow counter loaded all-ones: every count must be consumed exactly once.
    hs = 0; dones = 0;
    nb4 = 4'hF; start4 = 1'b1;
    step(); start4 = 1'b0;
    for (int k = 0; k < 400; k++) begin
      valid4 = ($urandom_range(0, 3) != 0);
      ready4 = ($urandom_range(0, 2) != 0);
      d4   = '{$urandom, $urandom};
      rnd4 = '{$urandom};
      if (blk_valid4 && ready4) begin
        hs++;
        checks++;
        if ((blk4[0] ^ blk4[1]) === '0 && blk4[0] === '0) begin
          errors++; $display("FAIL cnt4_blk_zero: got blk=%h expected nonzero capture", blk4[0]);
        end
      end
      step();
      if (done4) dones++;
    end
    checks++;
    if (hs != 15 || dones != 1 || busy4 !== 1'b0) begin
      errors++; $display("FAIL cnt4_allones: got hs=%0d dones=%0d busy=%b expected 15 1 0", hs, dones, busy4);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; nblocks = '0; valid = 1'b0; blk_ready = 1'b0;
    d = '{default: '0}; rnd = '{default: '0};
    start4 = 1'b0; nb4 = '0; valid4 = 1'b0; ready4 = 1'b0;
    d4 = '{default: '0}; rnd4 = '{default: '0};
    test_reset();
    test_full_run();
    test_zero_blocks();
    test_backpressure();
    test_stall();
    test_reset_mid();
    test_counter_width();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
